// File: rtl/phy_pkg.sv
// Shared link-layer constants and types for the PHY transmit/receive schedulers.
package phy_pkg;

  localparam int unsigned LANE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned DATA_W         = LANE_W * BYTES_PER_WORD;
  localparam int unsigned WCNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_LOW = 2'd2
  } state_e;

  // Index width that stays legal for a single-port configuration.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phy_link_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr_i, with wrap.
module rr_arbiter
  import phy_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 4,
  localparam int unsigned IDX_W     = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     rr_ptr_i,
  output logic [NUM_PORTS-1:0] win_oh_o,
  output logic [IDX_W-1:0]     win_idx_o
);

  int unsigned p;
  logic        found;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    p         = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      p = 32'(rr_ptr_i) + i;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      if (!found && req_i[IDX_W'(p)]) begin
        found                  = 1'b1;
        win_oh_o[IDX_W'(p)]    = 1'b1;
        win_idx_o              = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/phy_link_scheduler.sv
// Transmit scheduler for one link: round-robin port select, then a four-phase
// req/ack byte serializer (MSB byte first) guarded by an ack-timeout watchdog.
module phy_link_scheduler
  import phy_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LANE_W      = 8,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*DATA_W-1:0] data_in,
  output logic [NUM_PORTS-1:0]        grant,
  output logic                        link_req,
  input  logic                        link_ack,
  output logic [LANE_W-1:0]           serial_data_out,
  output logic                        busy,
  output logic                        timeout_err,
  input  logic                        err_clr,
  output logic [WCNT_W-1:0]           words_sent
);

  localparam int unsigned IDX_W = idx_w(NUM_PORTS);
  localparam int unsigned BC_W  = $clog2(BYTES_PER_WORD);
  localparam int unsigned WD_W  = $clog2(ACK_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    winner_q, winner_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [LANE_W-1:0]   serial_q, serial_d;
  logic                link_req_q, link_req_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [WCNT_W-1:0]   words_q, words_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [WD_W-1:0]     wd_q, wd_d;

  logic [NUM_PORTS-1:0] win_oh;
  logic [IDX_W-1:0]     win_idx;
  logic [DATA_W-1:0]    cap_word;
  logic [IDX_W-1:0]     next_ptr;
  logic                 wd_expired;
  logic                 abort;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .req_i     (req),
    .rr_ptr_i  (rr_ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx)
  );

  // Word of the arbitration winner.
  always_comb begin
    cap_word = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (win_oh[p]) cap_word = data_in[p*DATA_W +: DATA_W];
    end
  end

  assign next_ptr   = (winner_q == IDX_W'(NUM_PORTS - 1)) ? '0 : winner_q + IDX_W'(1);
  assign wd_expired = (wd_q == WD_W'(ACK_TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    winner_d   = winner_q;
    shreg_d    = shreg_q;
    serial_d   = serial_q;
    link_req_d = link_req_q;
    grant_d    = '0;
    words_d    = words_q;
    byte_cnt_d = byte_cnt_q;
    abort      = 1'b0;
    err_d      = err_clr ? 1'b0 : err_q;
    wd_d       = (state_q == IDLE) ? '0 : wd_q + WD_W'(1);

    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d    = win_oh;
          winner_d   = win_idx;
          serial_d   = cap_word[DATA_W-1 -: LANE_W];
          shreg_d    = cap_word << LANE_W;
          link_req_d = 1'b1;
          byte_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (link_ack) begin
          link_req_d = 1'b0;
          state_d    = WAIT_LOW;
        end else if (wd_expired) begin
          abort = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!link_ack) begin
          if (byte_cnt_q == BC_W'(BYTES_PER_WORD - 1)) begin
            words_d  = words_q + WCNT_W'(1);
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + BC_W'(1);
            serial_d   = shreg_q[DATA_W-1 -: LANE_W];
            shreg_d    = shreg_q << LANE_W;
            link_req_d = 1'b1;
            state_d    = SEND;
          end
        end else if (wd_expired) begin
          abort = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog abort drops the word; a pending err_clr loses to the new error.
    if (abort) begin
      link_req_d = 1'b0;
      err_d      = 1'b1;
      rr_ptr_d   = next_ptr;
      state_d    = IDLE;
    end
    if (state_d != state_q) wd_d = '0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      winner_q   <= '0;
      shreg_q    <= '0;
      serial_q   <= '0;
      link_req_q <= 1'b0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= '0;
      byte_cnt_q <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      winner_q   <= winner_d;
      shreg_q    <= shreg_d;
      serial_q   <= serial_d;
      link_req_q <= link_req_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      words_q    <= words_d;
      byte_cnt_q <= byte_cnt_d;
      wd_q       <= wd_d;
    end
  end

  assign grant           = grant_q;
  assign link_req        = link_req_q;
  assign serial_data_out = serial_q;
  assign busy            = busy_q;
  assign timeout_err     = err_q;
  assign words_sent      = words_q;

endmodule

// File: tb/tb_phy_link_scheduler.sv
// Directed scoreboard bench for phy_link_scheduler with an in-bench four-phase peer.
module tb_phy_link_scheduler;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned TO = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req;
  logic [NP*DW-1:0] data_in;
  logic [NP-1:0]    grant;
  logic             link_req;
  logic             link_ack = 1'b0;
  logic [LW-1:0]    serial_data_out;
  logic             busy;
  logic             timeout_err;
  logic             err_clr;
  logic [15:0]      words_sent;

  logic             peer_en;
  logic             ack_force;
  logic             lr_prev;
  logic [NP-1:0]    g_prev;
  logic [7:0]       exp_bytes[$];
  logic [NP-1:0]    exp_grants[$];
  int               total = 0;
  int               bad = 0;

  always #5 clk = ~clk;

  phy_link_scheduler #(
    .NUM_PORTS(NP), .DATA_W(DW), .LANE_W(LW), .ACK_TIMEOUT(TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .data_in         (data_in),
    .grant           (grant),
    .link_req        (link_req),
    .link_ack        (link_ack),
    .serial_data_out (serial_data_out),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .err_clr         (err_clr),
    .words_sent      (words_sent)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: peer acts on the falling edge, outputs are sampled 1 unit after the rising edge.
  task automatic tick();
    logic [7:0]    eb;
    logic [NP-1:0] eg;
    @(negedge clk);
    link_ack = peer_en ? link_req : ack_force;
    @(posedge clk);
    #1;
    if (link_req && !lr_prev) begin
      if (exp_bytes.size() == 0) check("byte_unexpected", 32'(serial_data_out), 32'h100);
      else begin
        eb = exp_bytes.pop_front();
        check("byte", 32'(serial_data_out), 32'(eb));
      end
    end
    if (grant != '0) begin
      if (exp_grants.size() == 0) check("grant_unexpected", 32'(grant), 32'h10);
      else begin
        eg = exp_grants.pop_front();
        check("grant", 32'(grant), 32'(eg));
      end
      check("grant_pulse", 32'(g_prev), 32'h0);
    end
    lr_prev = link_req;
    g_prev  = grant;
  endtask

  task automatic push_word(input int p, input logic [31:0] w);
    exp_grants.push_back(4'(1 << p));
    for (int b = 0; b < 4; b++) exp_bytes.push_back(w[31-8*b -: 8]);
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (grant == '0 && n < 40);
    check({tag, "_grant_seen"}, 32'(grant != '0), 32'h1);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_byte(input string tag, input logic [7:0] b);
    int n;
    n = 0;
    while (!(link_req && serial_data_out == b) && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_byte_seen"}, 32'(link_req && serial_data_out == b), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=hang expected=finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b1; req = '0; data_in = '0; err_clr = 1'b0;
    peer_en = 1'b0; ack_force = 1'b0; lr_prev = 1'b0; g_prev = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_link_req", 32'(link_req), 32'h0);
    check("rst_serial", 32'(serial_data_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(timeout_err), 32'h0);
    check("rst_words", 32'(words_sent), 32'h0);

    // single word, zero-latency peer
    peer_en = 1'b1;
    data_in[0 +: DW] = 32'hA1B2C3D4;
    push_word(0, 32'hA1B2C3D4);
    req = 4'b0001;
    wait_grant("t1");
    req = '0;
    check("t1_busy", 32'(busy), 32'h1);
    wait_idle(cyc);
    check("t1_busy_cycles", 32'(cyc), 32'd8);
    check("t1_words", 32'(words_sent), 32'd1);

    // all ports requesting: strict rotation from port 0 after reset
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int p = 0; p < 4; p++) data_in[p*DW +: DW] = 32'h01020304 + 32'h10101010 * p;
    for (int w = 0; w < 8; w++) push_word(w % 4, 32'h01020304 + 32'h10101010 * (w % 4));
    req = 4'b1111;
    for (int w = 0; w < 8; w++) wait_grant("t2");
    req = '0;
    wait_idle(cyc);
    check("t2_words", 32'(words_sent), 32'd8);

    // peer never acks: abort 10 cycles after SEND entry
    peer_en = 1'b0; ack_force = 1'b0;
    data_in[1*DW +: DW] = 32'hDEADBEEF;
    exp_grants.push_back(4'b0010);
    exp_bytes.push_back(8'hDE);
    req = 4'b0010;
    wait_grant("t3");
    req = '0;
    cyc = 0;
    while (link_req && cyc < 50) begin tick(); cyc++; end
    check("t3_timeout_cycles", 32'(cyc), 32'd10);
    check("t3_err", 32'(timeout_err), 32'h1);
    check("t3_words", 32'(words_sent), 32'd8);
    check("t3_busy", 32'(busy), 32'h0);
    // pointer moved past the aborted port: port 2 beats port 1
    peer_en = 1'b1;
    data_in[2*DW +: DW] = 32'h55667788;
    push_word(2, 32'h55667788);
    push_word(1, 32'hDEADBEEF);
    req = 4'b0110;
    wait_grant("t3b");
    req = 4'b0010;
    wait_grant("t3c");
    req = '0;
    wait_idle(cyc);
    check("t3_words_after", 32'(words_sent), 32'd10);
    check("t3_err_sticky", 32'(timeout_err), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3_err_clr", 32'(timeout_err), 32'h0);

    // ack stuck high during byte 2: WAIT_LOW times out
    data_in[3*DW +: DW] = 32'h0A0B0C0D;
    exp_grants.push_back(4'b1000);
    exp_bytes.push_back(8'h0A);
    exp_bytes.push_back(8'h0B);
    req = 4'b1000;
    wait_grant("t4");
    req = '0;
    wait_byte("t4", 8'h0B);
    peer_en = 1'b0; ack_force = 1'b1;
    tick();
    check("t4_wait_low_req", 32'(link_req), 32'h0);
    check("t4_wait_low_busy", 32'(busy), 32'h1);
    wait_idle(cyc);
    check("t4_timeout_cycles", 32'(cyc), 32'd10);
    check("t4_err", 32'(timeout_err), 32'h1);
    check("t4_words", 32'(words_sent), 32'd10);
    repeat (3) tick();
    check("t4_idle_ack_ignored", 32'({busy, link_req}), 32'h0);
    ack_force = 1'b0;

    // reset in the middle of byte 2
    peer_en = 1'b1;
    data_in[0 +: DW] = 32'h11223344;
    exp_grants.push_back(4'b0001);
    exp_bytes.push_back(8'h11);
    exp_bytes.push_back(8'h22);
    req = 4'b0001;
    wait_grant("t5");
    req = '0;
    wait_byte("t5", 8'h22);
    rst = 1'b1;
    #1;
    check("t5_grant", 32'(grant), 32'h0);
    check("t5_link_req", 32'(link_req), 32'h0);
    check("t5_serial", 32'(serial_data_out), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_err", 32'(timeout_err), 32'h0);
    check("t5_words", 32'(words_sent), 32'h0);
    tick(); tick();
    rst = 1'b0;
    data_in[2*DW +: DW] = 32'h99AABBCC;
    push_word(2, 32'h99AABBCC);
    req = 4'b0100;
    wait_grant("t5b");
    req = '0;
    wait_idle(cyc);
    check("t5_busy_cycles", 32'(cyc), 32'd8);
    check("t5_words_after", 32'(words_sent), 32'd1);

    // ack lands on the timeout cycle in SEND, release lands on it in WAIT_LOW
    peer_en = 1'b0; ack_force = 1'b0;
    data_in[0 +: DW] = 32'hCAFEF00D;
    push_word(0, 32'hCAFEF00D);
    req = 4'b0001;
    wait_grant("t6");
    req = '0;
    repeat (9) tick();
    check("t6_no_early_abort", 32'(link_req), 32'h1);
    ack_force = 1'b1;
    tick();
    check("t6_send_exit", 32'(link_req), 32'h0);
    check("t6_send_busy", 32'(busy), 32'h1);
    check("t6_send_err", 32'(timeout_err), 32'h0);
    repeat (9) tick();
    ack_force = 1'b0;
    tick();
    check("t6_wait_exit", 32'(link_req), 32'h1);
    check("t6_second_byte", 32'(serial_data_out), 32'hFE);
    check("t6_wait_err", 32'(timeout_err), 32'h0);
    peer_en = 1'b1;
    wait_idle(cyc);
    check("t6_words", 32'(words_sent), 32'd2);
    check("t6_err_final", 32'(timeout_err), 32'h0);

    tick();
    check("bytes_left", 32'(exp_bytes.size()), 32'h0);
    check("grants_left", 32'(exp_grants.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phy_link_scheduler.md
# phy_link_scheduler

Transmit-side controller for one physical link. Round-robin arbitration between `NUM_PORTS` router output queues. Serializes the granted 32-bit word onto the 8-bit link lane, MSB byte first, using a four-phase `link_req`/`link_ack` handshake per byte. Sits between the router's per-port output buffers and the link pins, ahead of the peer's receive deserializer. An ack-timeout watchdog raises a sticky error flag.

## Interface
- `NUM_PORTS`, 4: number of requesting router ports (≥1)
- `DATA_W`, 32: word width; must equal `LANE_W*4`
- `LANE_W`, 8: serial lane width
- `ACK_TIMEOUT`, 255: cycles allowed in any handshake wait state before abort (≥2)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `req` in NUM_PORTS: per-port word available; word must be held stable on `data_in` while req high
- `data_in` in NUM_PORTS*DATA_W: port p word at bits [p*DATA_W +: DATA_W]
- `grant` out NUM_PORTS: registered one-hot, one-cycle pulse; word of that port consumed
- `link_req` out 1: byte valid on `serial_data_out` (to peer `read_req_received`)
- `link_ack` in 1: peer byte acknowledge (from peer `write_ready_ack`), asynchronous to our handshake phase but synchronous to `clk`
- `serial_data_out` out LANE_W: current byte
- `busy` out 1: high whenever state ≠ IDLE
- `timeout_err` out 1: sticky, set on watchdog abort
- `err_clr` in 1: clears `timeout_err`
- `words_sent` out 16: completed-word counter, wraps 0xFFFF→0

## Operation
- States: IDLE, SEND, WAIT_LOW.
- IDLE: if any `req` bit is sampled high, the winner is the first requesting port at or after `rr_ptr`, scanning upward with wrap. Same edge: capture winner's word into shift register, `grant[winner]`<=1, `serial_data_out`<=word[31:24], `link_req`<=1, `byte_cnt`<=0, go SEND. No request: stay, outputs hold.
- SEND: `link_req` high. `link_ack` sampled 1: `link_req`<=0, go WAIT_LOW.
- WAIT_LOW: `link_ack` sampled 0:
  - `byte_cnt`==3: `words_sent`+=1, `rr_ptr`<=winner+1 (mod NUM_PORTS), go IDLE.
  - otherwise: `byte_cnt`+=1, next byte (23:16, 15:8, 7:0) onto `serial_data_out`, `link_req`<=1, go SEND.
- Watchdog: a counter clears on every state change and increments each cycle in SEND/WAIT_LOW. On reaching `ACK_TIMEOUT` with no exit condition: `link_req`<=0, `timeout_err`<=1, word dropped (no count), `rr_ptr`<=winner+1, go IDLE.
- `serial_data_out` holds its last byte in IDLE.

## Timing
- Reset values: `grant`=0, `link_req`=0, `serial_data_out`=0, `busy`=0, `timeout_err`=0, `words_sent`=0, `rr_ptr`=0, state IDLE.
- `grant` is high exactly one cycle, the cycle after the capture edge. The requester may change `data_in`/`req` from that cycle on.
- Minimum word time with a zero-latency peer: 1 IDLE + 4×(SEND+WAIT_LOW) = 9 cycles. Back-to-back words from one port are separated by ≥1 IDLE cycle.
- `link_ack` high while IDLE is ignored. `link_ack` already high on entry to SEND completes that phase at the next edge.
- Exit condition and timeout in the same cycle: the exit condition wins, and no error is raised.
- `err_clr` and a new timeout in the same cycle: set wins.
- `req` dropped before the IDLE sampling edge: no grant. `req` from a port while another port's word is in flight: that port waits; no starvation, bounded by NUM_PORTS words.
- `rst` mid-word: immediate return to reset values; the partial word is lost, and the peer sees `link_req` fall.

## Structure
- Shared package `phy_pkg`: `LANE_W`, `DATA_W`, `BYTES_PER_WORD`=4, state enum (IDLE/SEND/WAIT_LOW), word-counter width.
- Sub-module `rr_arbiter`: combinational; inputs `req`, `rr_ptr`; outputs one-hot winner and index. Reused by the future receive-side scheduler.

## Test plan
- `req`=0001, `data_in[0]`=0xA1B2C3D4, peer acks after 1 cycle -> bytes A1,B2,C3,D4 in order, `grant`=0001 once, `words_sent`=1, 9-cycle word.
- `req`=1111 held for 8 words -> grant order ports 0,1,2,3,0,1,2,3, `words_sent`=8.
- Peer never acks, ACK_TIMEOUT=10 -> `link_req` falls 10 cycles after SEND entry, `timeout_err`=1, `words_sent` unchanged, next port granted; `err_clr` pulse -> `timeout_err`=0.
- `link_ack` stuck high after byte 2 -> WAIT_LOW times out, error set, state IDLE.
- `rst` asserted during byte 2 of 0x11223344 -> all outputs at reset values immediately; after release, `req`=0100 gives port 2 the grant (`rr_ptr`=0 scan).
- Ack and timeout on the same cycle (ack arrives at cycle ACK_TIMEOUT) -> byte completes, no error.
